// File: rtl/dbg_reg_access.sv
// Debug abstract register access: arbitrates register-file read port 1 and the write port
// between the core pipeline and debug requests. DBG_REG_ACCESS_READBACK_EN adds read-back after writes.
module dbg_reg_access #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             halted,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [AW-1:0]    req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   input  logic [AW-1:0]    core_rd_addr1,
   input  logic [AW-1:0]    core_wr_addr,
   input  logic [WIDTH-1:0] core_wr_data,
   input  logic             core_wr_en,
   output logic [AW-1:0]    rf_rd_addr1,
   input  logic [WIDTH-1:0] rf_rd_data1,
   output logic [AW-1:0]    rf_wr_addr,
   output logic [WIDTH-1:0] rf_wr_data,
   output logic             rf_wr_en
);

   // state | meaning
   // IDLE  | ready for a request; register file owned by the core
   // READ  | debug owns read port 1, captures read data
   // WRITE | debug owns write port, core write dropped
   // RESP  | response held until rsp_ready
   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_rdata;
   logic             r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (!halted)        w_state_nxt = S_RESP;
               else if (req_write) w_state_nxt = S_WRITE;
               else                w_state_nxt = S_READ;
            end
         end
         S_READ: w_state_nxt = S_RESP;
`ifdef DBG_REG_ACCESS_READBACK_EN
         S_WRITE: w_state_nxt = S_READ;
`else
         S_WRITE: w_state_nxt = S_RESP;
`endif
         S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready   = (r_state == S_IDLE);
      rsp_valid   = (r_state == S_RESP);
      rf_rd_addr1 = core_rd_addr1;
      rf_wr_addr  = core_wr_addr;
      rf_wr_data  = core_wr_data;
      rf_wr_en    = core_wr_en;
      case (r_state)
         S_READ: rf_rd_addr1 = r_addr;
         S_WRITE: begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = r_addr;
            rf_wr_data = r_wdata;
         end
         default: ;
      endcase
   end

   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // halted is sampled only here; later changes do not abort an access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  if (!halted) begin
                     r_err   <= 1'b1;
                     r_rdata <= '0;
                  end else begin
                     r_err   <= 1'b0;
                  end
               end
            end
            S_READ:  r_rdata <= rf_rd_data1;
            S_WRITE: r_rdata <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_reg_access.sv
// Scoreboard bench for dbg_reg_access: directed requests push expected responses,
// a monitor pops and compares on each response handshake.
module tb_dbg_reg_access;
   localparam int W  = 32;
   localparam int AW = 5;
`ifdef DBG_REG_ACCESS_READBACK_EN
   localparam int WLAT = 3;
`else
   localparam int WLAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          halted = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [W-1:0]  req_wdata = '0;
   logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [W-1:0]  rsp_rdata;
   logic [AW-1:0] core_rd_addr1 = '0, core_wr_addr = '0;
   logic [W-1:0]  core_wr_data = '0;
   logic          core_wr_en = 1'b0;
   logic [AW-1:0] rf_rd_addr1, rf_wr_addr;
   logic [W-1:0]  rf_rd_data1, rf_wr_data;
   logic          rf_wr_en;

   always #5 clk = ~clk;

   dbg_reg_access #(.WIDTH(W), .DEPTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .halted(halted),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .core_rd_addr1(core_rd_addr1), .core_wr_addr(core_wr_addr),
      .core_wr_data(core_wr_data), .core_wr_en(core_wr_en),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_data1(rf_rd_data1),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en)
   );

   // register file model: x0 reads zero, writes land on the clock edge
   logic [W-1:0] rf [32];
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   always @(posedge clk) if (rf_wr_en && rf_wr_addr != '0) rf[rf_wr_addr] <= rf_wr_data;
   assign rf_rd_data1 = (rf_rd_addr1 == '0) ? '0 : rf[rf_rd_addr1];

   int          n_pass = 0, n_total = 0;
   int          wr_cnt = 0;
   logic [AW-1:0] last_wr_addr = '0;
   logic [W:0]  exp_q [$];

   always @(posedge clk) if (rf_wr_en) begin
      wr_cnt++;
      last_wr_addr = rf_wr_addr;
   end

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // monitor: compare every response handshake against the queued expectation
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL rsp_unexpected: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e[W:1]);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[0]});
         end
      end
   end

   function automatic logic [W-1:0] wr_rsp(input logic [AW-1:0] a, input logic [W-1:0] d);
`ifdef DBG_REG_ACCESS_READBACK_EN
      return (a == '0) ? '0 : d;
`else
      return '0;
`endif
   endfunction

   task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] wd,
                         input logic [W-1:0] erd, input logic eerr, input int elat,
                         input logic collide);
      int n;
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
      exp_q.push_back({erd, eerr});
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd;
      if (collide) begin core_wr_en = 1'b1; core_wr_addr = a; core_wr_data = 32'h1111; end
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         core_wr_en = 1'b0;
         lat++;
         @(negedge clk);
      end
      core_wr_en = 1'b0;
      chk("latency", lat, elat);
      if (rsp_ready) begin @(posedge clk); #1; end
   endtask

   initial begin
      int c0;
      #2;
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 0);
      chk("rst_req_ready", {31'b0, req_ready}, 1);
      chk("rst_rf_wr_en", {31'b0, rf_wr_en}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // write then read x5
      halted = 1'b1;
      c0 = wr_cnt;
      do_req(1'b1, 5'd5, 32'hDEADBEEF, wr_rsp(5'd5, 32'hDEADBEEF), 1'b0, WLAT, 1'b0);
      chk("x5_wr_pulses", wr_cnt - c0, 1);
      chk("x5_wr_addr", {27'b0, last_wr_addr}, 5);
      do_req(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);

      // rejected while running
      halted = 1'b0;
      c0 = wr_cnt;
      do_req(1'b0, 5'd3, 32'h0, 32'h0, 1'b1, 1, 1'b0);
      do_req(1'b1, 5'd5, 32'h0BADF00D, 32'h0, 1'b1, 1, 1'b0);
      chk("reject_no_write", wr_cnt - c0, 0);
      halted = 1'b1;
      do_req(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);

      // x0 write is issued but discarded
      do_req(1'b1, 5'd0, 32'h12345678, 32'h0, 1'b0, WLAT, 1'b0);
      do_req(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 2, 1'b0);

      // debug wins over a coincident core write
      do_req(1'b1, 5'd7, 32'hA5A5A5A5, wr_rsp(5'd7, 32'hA5A5A5A5), 1'b0, WLAT, 1'b1);
      do_req(1'b0, 5'd7, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1'b0);

      // core pass-through in IDLE
      @(negedge clk);
      core_rd_addr1 = 5'd9; core_wr_en = 1'b1; core_wr_addr = 5'd9; core_wr_data = 32'h00000055;
      #1;
      chk("pass_rd_addr", {27'b0, rf_rd_addr1}, 9);
      chk("pass_wr_data", rf_wr_data, 32'h55);
      @(negedge clk);
      core_wr_en = 1'b0;
      chk("pass_rd_data", rf_rd_data1, 32'h55);
      do_req(1'b0, 5'd9, 32'h0, 32'h55, 1'b0, 2, 1'b0);

      // halted dropping mid-access does not abort it
      fork
         begin @(posedge clk); @(posedge clk); #1; halted = 1'b0; end
         do_req(1'b0, 5'd7, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1'b0);
      join
      halted = 1'b1;

      // back-pressure on the response
      rsp_ready = 1'b0;
      do_req(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd7;
         chk("stall_valid", {31'b0, rsp_valid}, 1);
         chk("stall_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("stall_err", {31'b0, rsp_err}, 0);
         chk("stall_req_ready", {31'b0, req_ready}, 0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_after_idle", {31'b0, req_ready}, 1);

      // reset during WRITE
      c0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd12; req_wdata = 32'h0000CAFE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstmid_wr_en_before", {31'b0, rf_wr_en}, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_wr_en", {31'b0, rf_wr_en}, 0);
      chk("rstmid_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rstmid_req_ready", {31'b0, req_ready}, 1);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstmid_no_write", wr_cnt - c0, 0);
      do_req(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 2, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
